// File: rtl/pes_elevator_pkg.sv
// Shared types and constants for the pes_elevator request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pes_elevator_pkg;

  localparam int   NFLOORS_DEF = 8;
  localparam logic DIR_UP      = 1'b1;
  localparam logic DIR_DOWN    = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_SERVING  = 2'd3
  } state_t;

  // True when exactly one bit of vec is set (callers zero-extend narrower vectors)
  function automatic logic onehot_ok(input logic [63:0] vec);
    return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/pes_floor_picker.sv
// SCAN target picker: nearest pending floor ahead, else reverse and take the nearest at/behind.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result when it is ready to dispatch.
module pes_floor_picker
  import pes_elevator_pkg::*;
#(
  parameter int NFLOORS = NFLOORS_DEF
) (
  input  logic [NFLOORS-1:0] pending,
  input  logic [NFLOORS-1:0] cur_floor,
  input  logic               dir,
  output logic [NFLOORS-1:0] target,
  output logic               found,
  output logic               new_dir
);

  logic [NFLOORS-1:0] above_mask, below_mask;
  logic [NFLOORS-1:0] up_cand, dn_cand, here;
  logic [NFLOORS-1:0] up_pick, dn_pick;

  // Masks of floors strictly above / below the car, and the nearest candidate on each side
  always_comb begin
    logic seen;
    above_mask = '0;
    below_mask = '0;
    up_pick    = '0;
    dn_pick    = '0;
    seen       = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      above_mask[i] = seen;
      seen          = seen | cur_floor[i];
    end
    seen = 1'b0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      below_mask[i] = seen;
      seen          = seen | cur_floor[i];
    end
    up_cand = pending & above_mask;
    dn_cand = pending & below_mask;
    here    = pending & cur_floor;
    // Lowest set bit above the car is the nearest going up
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (up_cand[i]) begin
        up_pick    = '0;
        up_pick[i] = 1'b1;
      end
    end
    // Highest set bit below the car is the nearest going down
    for (int i = 0; i < NFLOORS; i++) begin
      if (dn_cand[i]) begin
        dn_pick    = '0;
        dn_pick[i] = 1'b1;
      end
    end
  end

  // Keep direction while work lies ahead; otherwise reverse, serving the current floor first
  always_comb begin
    target  = '0;
    found   = 1'b0;
    new_dir = dir;
    if (dir == DIR_UP) begin
      if (up_cand != '0) begin
        target = up_pick;
        found  = 1'b1;
      end else if (here != '0) begin
        target  = here;
        found   = 1'b1;
        new_dir = DIR_DOWN;
      end else if (dn_cand != '0) begin
        target  = dn_pick;
        found   = 1'b1;
        new_dir = DIR_DOWN;
      end
    end else begin
      if (dn_cand != '0) begin
        target = dn_pick;
        found  = 1'b1;
      end else if (here != '0) begin
        target  = here;
        found   = 1'b1;
        new_dir = DIR_UP;
      end else if (up_cand != '0) begin
        target  = up_pick;
        found   = 1'b1;
        new_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/pes_elevator_req_sched.sv
// Latches call buttons into a pending bitmap and issues one-hot SCAN-ordered targets to pes_elevator.
// Latency: call captured -> req_valid high 3 clocks later (IDLE -> SELECT -> DISPATCH -> SERVING).
// Backpressure: holds request_floor until complete is seen low then high at the target; optional PES_FIRE_RECALL_EN.
module pes_elevator_req_sched
  import pes_elevator_pkg::*;
#(
  parameter int NFLOORS     = NFLOORS_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] call_btn,
  input  logic [NFLOORS-1:0] cur_floor,
  input  logic               complete,
`ifdef PES_FIRE_RECALL_EN
  input  logic               fire_recall,
`endif
  output logic [NFLOORS-1:0] request_floor,
  output logic               req_valid,
  output logic               sched_dir,
  output logic [NFLOORS-1:0] pending,
  output logic               stall_alert,
  output logic               floor_err
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [NFLOORS-1:0] FLOOR0 = NFLOORS'(1);

  state_t             state, state_n;
  logic [NFLOORS-1:0] pending_n, target, target_n, req_floor_n, calls;
  logic [NFLOORS-1:0] pick_target;
  logic               pick_found, pick_dir;
  logic               req_valid_n, dir_n, seen_low, seen_low_n, retire;
  logic [CW-1:0]      stall_cnt, stall_cnt_n;
`ifdef PES_FIRE_RECALL_EN
  logic               parked, parked_n;
`endif

  pes_floor_picker #(.NFLOORS(NFLOORS)) u_picker (
    .pending   (pending),
    .cur_floor (cur_floor),
    .dir       (sched_dir),
    .target    (pick_target),
    .found     (pick_found),
    .new_dir   (pick_dir)
  );

  assign floor_err   = !onehot_ok(64'(cur_floor));
  assign stall_alert = (stall_cnt == CW'(TIMEOUT_CYC));
  // Only retire once a fresh complete edge arrives with the car at the held target
  assign retire      = (state == ST_SERVING) && seen_low && complete && (cur_floor == request_floor);

`ifdef PES_FIRE_RECALL_EN
  assign calls = fire_recall ? '0 : call_btn;
`else
  assign calls = call_btn;
`endif

  // Next-state and datapath updates; every target defaults to holding its value
  always_comb begin
    state_n     = state;
    target_n    = target;
    req_floor_n = request_floor;
    req_valid_n = req_valid;
    dir_n       = sched_dir;
    seen_low_n  = seen_low;
    stall_cnt_n = stall_cnt;
    // A same-cycle call for the retiring floor is dropped: the car is already there
    pending_n   = (pending | calls) & ~(retire ? request_floor : '0);
`ifdef PES_FIRE_RECALL_EN
    parked_n    = parked;
    if (fire_recall) pending_n = '0;
`endif
    case (state)
      ST_IDLE: begin
        if (pending != '0) state_n = ST_SELECT;
      end
      ST_SELECT: begin
        if (pending == '0) begin
          state_n = ST_IDLE;
        end else if (!floor_err && pick_found) begin
          target_n = pick_target;
          dir_n    = pick_dir;
          state_n  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        req_floor_n = target;
        req_valid_n = 1'b1;
        seen_low_n  = 1'b0;
        stall_cnt_n = '0;
        state_n     = ST_SERVING;
      end
      ST_SERVING: begin
        if (retire) begin
          req_floor_n = '0;
          req_valid_n = 1'b0;
          stall_cnt_n = '0;
          state_n     = (pending_n != '0) ? ST_SELECT : ST_IDLE;
        end else begin
          if (!complete) seen_low_n = 1'b1;
          if (stall_cnt != CW'(TIMEOUT_CYC)) stall_cnt_n = stall_cnt + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
`ifdef PES_FIRE_RECALL_EN
    // Recall overrides normal scheduling until the car has parked at floor 0
    if (!fire_recall) begin
      parked_n = 1'b0;
    end else begin
      if (retire) parked_n = 1'b1;
      if (!parked && ((state == ST_SERVING && request_floor != FLOOR0) ||
                      state == ST_IDLE || state == ST_SELECT)) begin
        req_floor_n = '0;
        req_valid_n = 1'b0;
        stall_cnt_n = '0;
        target_n    = FLOOR0;
        dir_n       = DIR_DOWN;
        state_n     = ST_DISPATCH;
      end
    end
`endif
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pending       <= '0;
      target        <= '0;
      request_floor <= '0;
      req_valid     <= 1'b0;
      sched_dir     <= DIR_UP;
      seen_low      <= 1'b0;
      stall_cnt     <= '0;
`ifdef PES_FIRE_RECALL_EN
      parked        <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      target        <= target_n;
      request_floor <= req_floor_n;
      req_valid     <= req_valid_n;
      sched_dir     <= dir_n;
      seen_low      <= seen_low_n;
      stall_cnt     <= stall_cnt_n;
`ifdef PES_FIRE_RECALL_EN
      parked        <= parked_n;
`endif
    end
  end

endmodule

// File: tb/tb_pes_elevator_req_sched.sv
// Scoreboard bench for pes_elevator_req_sched: expected requests queued by stimulus, checked by a monitor.
// Latency: checks 3-clock call-to-request latency and stall timeout at 1024 SERVING cycles.
// Backpressure: a scripted elevator model drives cur_floor/complete; PES_FIRE_RECALL_EN adds recall checks.
module tb_pes_elevator_req_sched;

  localparam int NF  = 8;
  localparam int TMO = 1024;

  typedef struct {
    logic [NF-1:0] floor;
    logic          dir;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] call_btn = '0;
  logic [NF-1:0] cur_floor = 8'h01;
  logic          complete = 1'b0;
`ifdef PES_FIRE_RECALL_EN
  logic          fire_recall = 1'b0;
`endif
  logic [NF-1:0] request_floor, pending;
  logic          req_valid, sched_dir, stall_alert, floor_err;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  pes_elevator_req_sched #(.NFLOORS(NF), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_btn      (call_btn),
    .cur_floor     (cur_floor),
    .complete      (complete),
`ifdef PES_FIRE_RECALL_EN
    .fire_recall   (fire_recall),
`endif
    .request_floor (request_floor),
    .req_valid     (req_valid),
    .sched_dir     (sched_dir),
    .pending       (pending),
    .stall_alert   (stall_alert),
    .floor_err     (floor_err)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string name, input logic [NF-1:0] act, input logic [NF-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: each rising req_valid must match the oldest expected request
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req_valid && !prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got floor %02h dir %b expected no request", request_floor, sched_dir);
        end else begin
          e = sb.pop_front();
          chk8("sb_floor", request_floor, e.floor);
          chk1("sb_dir", sched_dir, e.dir);
        end
      end
      prev = req_valid;
    end
  end

  // One-cycle call pulse captured at the next rising edge
  task automatic press(input logic [NF-1:0] btn);
    @(posedge clk); #1 call_btn = btn;
    @(posedge clk); #1 call_btn = '0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !req_valid; k++) @(negedge clk);
    chk1("wait_req", req_valid, 1'b1);
  endtask

  // Elevator model: drop complete, travel, arrive at the target and raise complete
  task automatic serve(input int travel);
    @(posedge clk); #1 complete = 1'b0;
    repeat (travel) @(posedge clk);
    #1 cur_floor = request_floor; complete = 1'b1;
    for (int k = 0; k < 20 && req_valid; k++) @(negedge clk);
    chk1("retire", req_valid, 1'b0);
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (2) @(negedge clk);
    chk8("rst_request_floor", request_floor, 8'h00);
    chk1("rst_req_valid", req_valid, 1'b0);
    chk1("rst_sched_dir", sched_dir, 1'b1);
    chk8("rst_pending", pending, 8'h00);
    chk1("rst_stall_alert", stall_alert, 1'b0);
    chk1("rst_floor_err", floor_err, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single call from ground, 3-clock latency after capture
    sb.push_back('{8'h80, 1'b1});
    call_btn = 8'h80;
    @(posedge clk); #1 call_btn = '0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (req_valid) lat = k;
    end
    chki("t1_latency", lat, 3);
    serve(2);
    chk8("t1_pending_clear", pending, 8'h00);

    // 2: SCAN order 08, 80, then reverse to 02
    @(posedge clk); #1 cur_floor = 8'h04; complete = 1'b0;
    sb.push_back('{8'h08, 1'b1});
    sb.push_back('{8'h80, 1'b1});
    sb.push_back('{8'h02, 1'b0});
    press(8'h8A);
    @(negedge clk);
    chk8("t2_pending", pending, 8'h8A);
    for (int t = 0; t < 3; t++) begin
      wait_req();
      serve(2);
    end
    chk8("t2_pending_done", pending, 8'h00);
    chk1("t2_dir_down", sched_dir, 1'b0);

    // 3: lingering complete at target must not retire until it drops and rises again
    sb.push_back('{8'h02, 1'b1});
    press(8'h02);
    wait_req();
    repeat (5) @(negedge clk);
    chk1("t3_no_early_retire", req_valid, 1'b1);
    @(posedge clk); #1 complete = 1'b0;
    @(posedge clk); #1 complete = 1'b1;
    @(posedge clk); @(negedge clk);
    chk1("t3_retired", req_valid, 1'b0);
    chk8("t3_pending", pending, 8'h00);

    // 4: stall alert after TMO cycles in SERVING, cleared on retire
    @(posedge clk); #1 complete = 1'b0;
    sb.push_back('{8'h10, 1'b1});
    press(8'h10);
    wait_req();
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk1("t4_alert_early", stall_alert, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("t4_alert", stall_alert, 1'b1);
    repeat (3) @(negedge clk);
    chk1("t4_still_waiting", req_valid, 1'b1);
    serve(1);
    chk1("t4_alert_clear", stall_alert, 1'b0);

    // 5: asynchronous reset mid-SERVING
    sb.push_back('{8'h20, 1'b1});
    press(8'h30);
    wait_req();
    chk8("t5_pending", pending, 8'h30);
    #1 reset = 1'b1;
    #1;
    chk8("t5_request_floor", request_floor, 8'h00);
    chk1("t5_req_valid", req_valid, 1'b0);
    chk1("t5_sched_dir", sched_dir, 1'b1);
    chk8("t5_pending_lost", pending, 8'h00);
    chk1("t5_stall_alert", stall_alert, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // floor_err: zero and multi-hot cur_floor, and SELECT holds while it is set
    cur_floor = 8'h00; #1;
    chk1("err_zero", floor_err, 1'b1);
    cur_floor = 8'h18; #1;
    chk1("err_multi", floor_err, 1'b1);
    cur_floor = 8'h00;
    press(8'h04);
    repeat (8) @(negedge clk);
    chk1("err_no_issue", req_valid, 1'b0);
    chk8("err_pending", pending, 8'h04);
    sb.push_back('{8'h04, 1'b1});
    @(posedge clk); #1 cur_floor = 8'h01;
    #1 chk1("err_clear", floor_err, 1'b0);
    wait_req();
    serve(2);

`ifdef PES_FIRE_RECALL_EN
    // 6: fire recall abandons 40, goes to floor 0, ignores calls until release
    sb.push_back('{8'h40, 1'b1});
    press(8'h40);
    wait_req();
    sb.push_back('{8'h01, 1'b0});
    @(posedge clk); #1 fire_recall = 1'b1; call_btn = 8'hFF;
    for (int k = 0; k < 10 && req_valid; k++) @(negedge clk);
    wait_req();
    chk8("t6_request_floor", request_floor, 8'h01);
    chk8("t6_pending", pending, 8'h00);
    serve(2);
    repeat (5) @(negedge clk);
    chk1("t6_parked", req_valid, 1'b0);
    chk8("t6_pending_parked", pending, 8'h00);
    @(posedge clk); #1 call_btn = '0;
    @(posedge clk); #1 fire_recall = 1'b0;
    repeat (3) @(negedge clk);
    chk1("t6_idle_after", req_valid, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chki("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
